// File: rtl/aes_pkg.sv
// Shared AES key-schedule primitives: S-box, RotWord/SubWord, RCON table and enums.
// Bytes inside a word are little-endian: FIPS-197 byte 0 of a word sits in bits [7:0].
package aes_pkg;

   typedef enum logic [1:0] {
      AES128  = 2'd0,
      AES192  = 2'd1,
      AES256  = 2'd2,
      AES_BAD = 2'd3
   } key_len_e;

   typedef enum logic {
      IDLE   = 1'b0,
      EXPAND = 1'b1
   } state_e;

   // Schedule word index width; 60 words is the largest schedule.
   localparam int WORD_IDX_W = 6;

   // Row 0 of the FIPS-197 S-box occupies the most significant bits.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // RCON[j] at bits [8j+:8]; RCON[0] is never used.
   localparam logic [87:0] RCON_TBL = {
      8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[8*(255 - int'(b)) +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[7:0], w[31:8]};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] j);
      logic [7:0] r;
      r = 8'h00;
      if (j <= 4'd10) r = RCON_TBL[8*int'(j) +: 8];
      return r;
   endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// Control, key and round-key read bundle between the key expander and its user.
// master drives start/key/read requests; slave is the expander.
interface aes_key_expand_seq_if #(
   parameter int MAX_NK   = 8,
   parameter int RD_IDX_W = 4
);
   logic                  start;
   logic [1:0]            key_len;
   logic [32*MAX_NK-1:0]  key;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [3:0]            nr;
   logic [RD_IDX_W:0]     rk_avail;
   logic                  rd_en;
   logic [RD_IDX_W-1:0]   rd_idx;
   logic [127:0]          rd_data;
   logic                  rd_valid;

   modport master (
      output start, key_len, key, rd_en, rd_idx,
      input  busy, done, err, nr, rk_avail, rd_data, rd_valid
   );

   modport slave (
      input  start, key_len, key, rd_en, rd_idx,
      output busy, done, err, nr, rk_avail, rd_data, rd_valid
   );
endinterface

// File: rtl/aes_key_word_calc.sv
// Combinational next schedule word w[i] from w[i-1] and w[i-Nk].
// Nk is 4, 6 or 8; the Nk=6 case needs a true divide-by-6 of the word index.
module aes_key_word_calc
   import aes_pkg::*;
(
   input  logic [31:0]           w_prev,
   input  logic [31:0]           w_back,
   input  logic [WORD_IDX_W-1:0] i,
   input  logic [3:0]            nk,
   output logic [31:0]           w_next
);
   logic [3:0] pos;
   logic [3:0] rnd;

   always_comb begin
      pos = 4'd0;
      rnd = 4'd0;
      case (nk)
         4'd4: begin
            pos = {2'b00, i[1:0]};
            rnd = i[5:2];
         end
         4'd6: begin
            pos = 4'(i % 6'd6);
            rnd = 4'(i / 6'd6);
         end
         default: begin
            pos = {1'b0, i[2:0]};
            rnd = {1'b0, i[5:3]};
         end
      endcase

      if (pos == 4'd0)
         w_next = w_back ^ sub_word(rot_word(w_prev)) ^ {24'h0, rcon(rnd)};
      else if (nk == 4'd8 && pos == 4'd4)
         w_next = w_back ^ sub_word(w_prev);
      else
         w_next = w_back ^ w_prev;
   end
endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128/192/256 key schedule, one word per clock into a register file.
// Round keys become readable (registered, one-cycle latency) as soon as each is complete.
module aes_key_expand_seq
   import aes_pkg::*;
#(
   parameter int MAX_NK   = 8,
   parameter int RD_IDX_W = 4
)(
   input  logic clk,
   input  logic rst,
   aes_key_expand_seq_if.slave bus
);
   localparam int NWORDS = 4 * (MAX_NK + 7);

   state_e                  state_q, state_d;
   logic [31:0]             wmem [NWORDS];
   logic [WORD_IDX_W-1:0]   widx_q;
   logic [3:0]              nk_q;
   logic [3:0]              nr_q;
   logic [RD_IDX_W:0]       rk_avail_q;
   logic [31:0]             w_prev_q;
   logic                    last_q;
   logic                    done_q;
   logic                    err_q;
   logic                    rd_valid_q;
   logic [127:0]            rd_data_q;

   logic                    go, bad, step, fin;
   logic                    len_ok;
   logic [3:0]              nk_sel;
   logic [31:0]             key_last;
   logic [31:0]             w_back;
   logic [31:0]             w_next;
   logic [WORD_IDX_W-1:0]   last_idx;
   logic                    rd_ok;
   logic [WORD_IDX_W-1:0]   rbase;
   logic [127:0]            rd_word;

   always_comb begin
      case (key_len_e'(bus.key_len))
         AES128:  nk_sel = 4'd4;
         AES192:  nk_sel = 4'd6;
         default: nk_sel = 4'd8;
      endcase
   end

   // A key longer than the configured storage is treated like key_len=3.
   assign len_ok   = (bus.key_len != 2'd3) && (nk_sel <= 4'(MAX_NK));
   assign key_last = bus.key[32*(int'(nk_sel) - 1) +: 32];
   assign last_idx = {nr_q, 2'b11};
   assign w_back   = wmem[widx_q - WORD_IDX_W'(nk_q)];

   always_comb begin
      state_d = state_q;
      go      = 1'b0;
      bad     = 1'b0;
      step    = 1'b0;
      fin     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (len_ok) begin
                  go      = 1'b1;
                  state_d = EXPAND;
               end else begin
                  bad = 1'b1;
               end
            end
         end
         EXPAND: begin
            step = 1'b1;
            if (widx_q == last_idx) begin
               fin     = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   aes_key_word_calc u_calc (
      .w_prev (w_prev_q),
      .w_back (w_back),
      .i      (widx_q),
      .nk     (nk_q),
      .w_next (w_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         widx_q     <= '0;
         nk_q       <= 4'd4;
         nr_q       <= 4'd0;
         rk_avail_q <= '0;
         last_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         err_q      <= bad;
         last_q     <= fin;
         done_q     <= last_q;
         rd_valid_q <= bus.rd_en;
         if (bus.rd_en) rd_data_q <= rd_word;
         if (go) begin
            nk_q       <= nk_sel;
            nr_q       <= nk_sel + 4'd6;
            widx_q     <= WORD_IDX_W'(nk_sel);
            rk_avail_q <= (RD_IDX_W+1)'(nk_sel >> 2);
         end else if (step) begin
            widx_q <= widx_q + 1'b1;
            if (widx_q[1:0] == 2'b11) rk_avail_q <= rk_avail_q + 1'b1;
         end
      end
   end

   // Storage and the w[i-1] forwarding register carry no reset.
   always_ff @(posedge clk) begin
      if (go) begin
         for (int k = 0; k < MAX_NK; k++) begin
            if (k < int'(nk_sel)) wmem[k] <= bus.key[32*k +: 32];
         end
         w_prev_q <= key_last;
      end else if (step) begin
         wmem[widx_q] <= w_next;
         w_prev_q     <= w_next;
      end
   end

   // rk_avail is the pre-edge count, so a key finishing this cycle still reads as 0.
   always_comb begin
      rd_ok   = ({1'b0, bus.rd_idx} < rk_avail_q) &&
                ({1'b0, bus.rd_idx} <= (RD_IDX_W+1)'(nr_q));
      rbase   = rd_ok ? WORD_IDX_W'({bus.rd_idx, 2'b00}) : '0;
      rd_word = '0;
      if (rd_ok)
         rd_word = {wmem[rbase + 2'd3], wmem[rbase + 2'd2], wmem[rbase + 2'd1], wmem[rbase]};
   end

   assign bus.busy     = (state_q == EXPAND);
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.nr       = nr_q;
   assign bus.rk_avail = rk_avail_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
Iterative AES key-schedule engine. Produces one 32-bit schedule word per clock for runtime-selectable AES-128, AES-192 or AES-256. Words go into an internal register file. Round keys are readable through a registered read port while expansion is still running, so a downstream iterative cipher core can start once round key 0 exists. It replaces the fully unrolled combinational expander where area matters more than latency.

Parameters:
MAX_NK, 8, largest key length in 32-bit words; sizes the key port and schedule storage (4*(MAX_NK+7) words); legal values 4, 6, 8.
RD_IDX_W, 4, width of round-key index; must be at least clog2(MAX_NK+7).

Ports:
clk  input  1  clock.
rst  input  1  reset.
start  input  1  begin expansion of key/key_len; accepted only in IDLE.
key_len  input  2  0=128, 1=192, 2=256, 3=illegal.
key  input  32*MAX_NK  cipher key; word i = key[32*i+:32]; FIPS-197 byte 0 in key[7:0]; unused upper words ignored.
busy  output  1  expansion in progress.
done  output  1  one-cycle pulse when the last word has been written.
err  output  1  one-cycle pulse when start arrives with key_len=3.
nr  output  4  round count of the current schedule (10/12/14); 0 until the first start.
rk_avail  output  RD_IDX_W+1  number of complete round keys written (0..Nr+1).
rd_en  input  1  read request.
rd_idx  input  RD_IDX_W  round-key index.
rd_data  output  128  {w[4r+3],w[4r+2],w[4r+1],w[4r]}, registered.
rd_valid  output  1  high the cycle after an accepted rd_en.

Behaviour:
- Reset: synchronous, active-high on clk. All control outputs return to their reset values on the next edge: busy=0, done=0, err=0, nr=0, rk_avail=0, rd_valid=0, rd_data=0, FSM=IDLE. Storage contents are don't-care. Reset mid-expansion aborts immediately; no done pulse follows.
- FSM has two states, IDLE and EXPAND.
- IDLE with start and key_len<3:
  - latch Nk (4/6/8) and Nr=Nk+6;
  - write words 0..Nk-1 from key in the same edge;
  - set word counter i=Nk, busy=1, rk_avail=Nk/4 (integer divide);
  - go to EXPAND.
- IDLE with start and key_len=3: pulse err the next cycle; stay in IDLE; previous schedule, nr and rk_avail are untouched.
- EXPAND: each cycle compute w[i] and write it, then i++. Word rule, using w[i-1] and w[i-Nk] from storage:
  - i%Nk==0: w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {24'h0,RCON[i/Nk]};
  - Nk==8 and i%Nk==4: w[i-Nk] ^ SubWord(w[i-1]);
  - otherwise: w[i-Nk] ^ w[i-1].
- rk_avail increments on the edge that writes a word with i%4==3.
- On the edge writing i=4*(Nr+1)-1: busy falls, done pulses the next cycle, FSM returns to IDLE.
- Total cycles from start edge to done high: 128 → 41, 192 → 47, 256 → 53.
- start while busy is ignored, with no err.
- The last word is written (w[i-1] forwarded) with no stall; throughput is exactly one word per cycle.
- Reads:
  - rd_en accepted any cycle; rd_data updates on the next edge; rd_valid=1 that cycle, else 0.
  - rd_idx >= rk_avail or rd_idx > Nr: rd_valid still pulses; rd_data=0.
  - A read on the same cycle as the write completing that round key returns 0; the written value is visible from the following cycle.
- The schedule persists in IDLE until the next accepted start. A new start clears rk_avail to Nk/4 on the start edge.

Decomposition:
- aes_pkg holds SubWord, RotWord, the RCON table and a key_len_e enum (AES128/AES192/AES256).
- One sub-module: aes_key_word_calc, a combinational next-word function taking (w_prev, w_back, i, Nk).
- The FSM, counter and register file stay in the top block.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c (FIPS byte order): done at cycle 41; round 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6 (FIPS byte order); round 0 equals the key.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: done at cycle 47, nr=12; round 12 = e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: done at cycle 53, nr=14; round 14 = fe4890d1e6188d0b046df344706c631e.
- Early read: during the AES-128 run, poll rd_idx=1 every cycle. Returns 0 while rk_avail<2, then the correct round-1 key; rk_avail increments every 4 cycles.
- Protocol: key_len=3 → err pulse, busy stays 0. start while busy → ignored; a second start after done → new schedule.
- Reset mid-op: assert rst at cycle 20 of an AES-256 run → busy=0, rk_avail=0, nr=0, no done. A fresh AES-128 start then completes correctly.
